// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared types and helpers for the memory request arbiter
package mem_arbiter_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Port index width; a single-entry index still needs one bit to be a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [BE_W-1:0]   be;
  } mem_req_t;

  typedef struct packed {
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
  } mem_rsp_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - requester-side and memory-side signals of the arbiter
interface mem_req_arbiter_if #(
  parameter int NR_PORTS     = 2,
  parameter int ADDRESS_SIZE = 64
);
  logic [NR_PORTS-1:0]                   req_i;
  logic [NR_PORTS-1:0][ADDRESS_SIZE-1:0] address_i;
  logic [NR_PORTS-1:0][31:0]             wdata_i;
  logic [NR_PORTS-1:0]                   we_i;
  logic [NR_PORTS-1:0][3:0]              be_i;
  logic [NR_PORTS-1:0]                   gnt_o;
  logic [NR_PORTS-1:0]                   rvalid_o;
  logic [NR_PORTS-1:0][31:0]             rdata_o;

  logic                    mem_req_o;
  logic [ADDRESS_SIZE-1:0] mem_address_o;
  logic [31:0]             mem_wdata_o;
  logic                    mem_we_o;
  logic [3:0]              mem_be_o;
  logic                    mem_gnt_i;
  logic                    mem_rvalid_i;
  logic [31:0]             mem_rdata_i;

  modport slave (
    input  req_i, address_i, wdata_i, we_i, be_i,
    output gnt_o, rvalid_o, rdata_o,
    output mem_req_o, mem_address_o, mem_wdata_o, mem_we_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output req_i, address_i, wdata_i, we_i, be_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  mem_req_o, mem_address_o, mem_wdata_o, mem_we_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter_id_fifo.sv
// rtl/mem_arbiter_id_fifo.sv - in-order FIFO of granted requester indices
module mem_arbiter_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = ptr_next(wptr_q);
    end
    if (do_pop) begin
      rptr_d = ptr_next(rptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin arbiter sharing one req/gnt/rvalid memory port
module mem_req_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NR_PORTS        = 2,
  parameter int ADDRESS_SIZE    = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  mem_req_arbiter_if.slave bus
);
  localparam int IDX_W = idx_width(NR_PORTS);
  typedef logic [IDX_W-1:0] idx_t;

  idx_t     rr_q, rr_d;
  logic     lock_vld_q, lock_vld_d;
  idx_t     lock_idx_q, lock_idx_d;
  idx_t     win, cand, fifo_head;
  logic     win_vld, mem_req, handshake, pop;
  logic     fifo_full, fifo_empty;
  mem_req_t win_req;
  mem_rsp_t rsp;

  // A requester left on the bus without a grant keeps the bus until it is served.
  always_comb begin
    win     = rr_q;
    win_vld = 1'b0;
    cand    = rr_q;
    if (lock_vld_q && bus.req_i[lock_idx_q]) begin
      win     = lock_idx_q;
      win_vld = 1'b1;
    end else begin
      for (int o = NR_PORTS - 1; o >= 0; o--) begin
        cand = idx_t'((int'(rr_q) + o) % NR_PORTS);
        if (bus.req_i[cand]) begin
          win     = cand;
          win_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_req = '0;
    if (win_vld) begin
      win_req.address = ADDR_W'(bus.address_i[win]);
      win_req.wdata   = bus.wdata_i[win];
      win_req.we      = bus.we_i[win];
      win_req.be      = bus.be_i[win];
    end
  end

  assign mem_req   = win_vld & ~fifo_full;
  assign handshake = mem_req & bus.mem_gnt_i;
  assign pop       = bus.mem_rvalid_i & ~fifo_empty;
  assign rsp       = '{rvalid: pop, rdata: bus.mem_rdata_i};

  assign bus.mem_req_o     = mem_req & rst_ni;
  assign bus.mem_address_o = ADDRESS_SIZE'(win_req.address);
  assign bus.mem_wdata_o   = win_req.wdata;
  assign bus.mem_we_o      = win_req.we;
  assign bus.mem_be_o      = win_req.be;

  always_comb begin
    bus.gnt_o    = '0;
    bus.rvalid_o = '0;
    if (handshake && rst_ni) begin
      bus.gnt_o[win] = 1'b1;
    end
    if (rsp.rvalid && rst_ni) begin
      bus.rvalid_o[fifo_head] = 1'b1;
    end
    for (int i = 0; i < NR_PORTS; i++) begin
      bus.rdata_o[i] = rsp.rdata;
    end
  end

  always_comb begin
    rr_d       = rr_q;
    lock_vld_d = lock_vld_q;
    lock_idx_d = lock_idx_q;
    if (handshake) begin
      rr_d       = (int'(win) == NR_PORTS - 1) ? '0 : idx_t'(int'(win) + 1);
      lock_vld_d = 1'b0;
    end else if (mem_req) begin
      lock_vld_d = 1'b1;
      lock_idx_d = win;
    end else if (lock_vld_q && !bus.req_i[lock_idx_q]) begin
      lock_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  mem_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (win),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // A response with nothing outstanding is dropped; flag it in simulation.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(bus.mem_rvalid_i && fifo_empty))
    else $error("mem_rvalid_i with no outstanding request");
endmodule
